// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer and next-PC selector for fetch.
// Optional 2-bit saturating counters: define BTB_SATURATING_COUNTER_EN.
module branch_target_buffer #(
   parameter int ENTRIES = 16,
   parameter int WORD    = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [WORD-1:0] if_pc,
   output logic            pred_hit,
   output logic            pred_taken,
   output logic [WORD-1:0] pred_next_pc,
   input  logic            upd_valid,
   input  logic [WORD-1:0] upd_pc,
   input  logic [WORD-1:0] upd_target,
   input  logic            upd_taken,
   input  logic            upd_is_jump
);

   localparam int IDX = $clog2(ENTRIES);
   localparam int TAG = WORD - IDX;

   logic [ENTRIES-1:0] valid_q;
   logic [TAG-1:0]     tag_q    [ENTRIES];
   logic [WORD-1:0]    target_q [ENTRIES];

   logic [IDX-1:0]  lk_idx;
   logic [TAG-1:0]  lk_tag;
   logic [IDX-1:0]  upd_idx;
   logic [TAG-1:0]  upd_tag;
   logic            upd_hit;
   logic            eff_taken;
   logic            valid_we;
   logic            valid_nxt;
   logic            tgt_we;
   logic [WORD-1:0] pc_inc;

   assign lk_idx    = if_pc[IDX-1:0];
   assign lk_tag    = if_pc[WORD-1:IDX];
   assign upd_idx   = upd_pc[IDX-1:0];
   assign upd_tag   = upd_pc[WORD-1:IDX];
   assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
   assign eff_taken = upd_taken || upd_is_jump;
   assign pc_inc    = if_pc + {{(WORD-1){1'b0}}, 1'b1};
   assign tgt_we    = upd_valid && eff_taken;

`ifdef BTB_SATURATING_COUNTER_EN
   logic [1:0] ctr_q [ENTRIES];
   logic [1:0] ctr_cur;
   logic [1:0] ctr_nxt;
   logic       ctr_we;

   assign ctr_cur = ctr_q[upd_idx];
   assign ctr_we  = upd_valid && (upd_hit || eff_taken);

   // Entries are only ever validated; not-taken just weakens the counter
   assign valid_we  = upd_valid && eff_taken;
   assign valid_nxt = 1'b1;

   // Counter training: jumps saturate, branches step, new branches start weak-taken
   always_comb begin
      ctr_nxt = ctr_cur;
      if (upd_is_jump) begin
         ctr_nxt = 2'b11;
      end else if (upd_taken) begin
         if (!upd_hit) begin
            ctr_nxt = 2'b10;
         end else if (ctr_cur != 2'b11) begin
            ctr_nxt = ctr_cur + 2'b01;
         end
      end else if (ctr_cur != 2'b00) begin
         ctr_nxt = ctr_cur - 2'b01;
      end
   end

   // Counter storage; reset to weakly not-taken
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_q[i] <= 2'b01;
         end
      end else if (ctr_we) begin
         ctr_q[upd_idx] <= ctr_nxt;
      end
   end

   // Lookup: taken prediction comes from the counter's upper bit
   always_comb begin
      pred_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      pred_taken   = pred_hit && ctr_q[lk_idx][1];
      pred_next_pc = pred_taken ? target_q[lk_idx] : pc_inc;
   end
`else
   // A not-taken hit drops the entry; a taken update (re)validates it
   assign valid_we  = upd_valid && (upd_hit || eff_taken);
   assign valid_nxt = eff_taken;

   // Lookup: any hit is predicted taken
   always_comb begin
      pred_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      pred_taken   = pred_hit;
      pred_next_pc = pred_taken ? target_q[lk_idx] : pc_inc;
   end
`endif

   // Valid bits; reset wins over a same-cycle update
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
      end else if (valid_we) begin
         valid_q[upd_idx] <= valid_nxt;
      end
   end

   // Tag and target storage, not reset; written on every taken update
   always_ff @(posedge clk) begin
      if (!reset && tgt_we) begin
         tag_q[upd_idx]    <= upd_tag;
         target_q[upd_idx] <= upd_target;
      end
   end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer.
// Expectations follow BTB_SATURATING_COUNTER_EN when defined.
module tb_branch_target_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] if_pc;
   logic        pred_hit;
   logic        pred_taken;
   logic [15:0] pred_next_pc;
   logic        upd_valid;
   logic [15:0] upd_pc;
   logic [15:0] upd_target;
   logic        upd_taken;
   logic        upd_is_jump;

`ifdef BTB_SATURATING_COUNTER_EN
   localparam bit CTR = 1'b1;
`else
   localparam bit CTR = 1'b0;
`endif

   typedef struct {
      logic [8*10-1:0] name;
      logic [15:0]     pc;
      logic            hit;
      logic            taken;
      logic [15:0]     npc;
   } exp_t;

   exp_t sb[$];
   logic chk_v = 1'b0;
   int   checks = 0;
   int   fails = 0;

   branch_target_buffer #(.ENTRIES(16), .WORD(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .if_pc        (if_pc),
      .pred_hit     (pred_hit),
      .pred_taken   (pred_taken),
      .pred_next_pc (pred_next_pc),
      .upd_valid    (upd_valid),
      .upd_pc       (upd_pc),
      .upd_target   (upd_target),
      .upd_taken    (upd_taken),
      .upd_is_jump  (upd_is_jump)
   );

   always #5 clk = ~clk;

   // One cycle: drive lookup and update, optionally queue expected lookup
   task automatic cyc(input logic [8*10-1:0] nm,
                      input logic rst,
                      input logic chk,
                      input logic [15:0] pc,
                      input logic e_hit,
                      input logic e_tk,
                      input logic [15:0] e_npc,
                      input logic uv,
                      input logic [15:0] upc,
                      input logic [15:0] utgt,
                      input logic utk,
                      input logic ujmp);
      exp_t e;
      @(posedge clk);
      #1;
      reset       = rst;
      if_pc       = pc;
      upd_valid   = uv;
      upd_pc      = upc;
      upd_target  = utgt;
      upd_taken   = utk;
      upd_is_jump = ujmp;
      chk_v       = chk;
      if (chk) begin
         e.name  = nm;
         e.pc    = pc;
         e.hit   = e_hit;
         e.taken = e_tk;
         e.npc   = e_npc;
         sb.push_back(e);
      end
   endtask

   // Monitor: compare lookup outputs mid-cycle, before the next update edge
   always @(negedge clk) begin
      if (chk_v) begin
         checks++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL sb_empty: lookup pc=%h with no expected entry", if_pc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (pred_hit !== e.hit || pred_taken !== e.taken ||
                pred_next_pc !== e.npc) begin
               fails++;
               $display("FAIL %0s pc=%h: got hit=%b taken=%b npc=%h, expected hit=%b taken=%b npc=%h",
                        e.name, e.pc, pred_hit, pred_taken, pred_next_pc,
                        e.hit, e.taken, e.npc);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      if_pc = 16'h0010;
      upd_valid = 1'b0;
      upd_pc = '0;
      upd_target = '0;
      upd_taken = 1'b0;
      upd_is_jump = 1'b0;

      // reset: second reset cycle sees cleared valid bits
      cyc("rst_hold", 1, 0, 16'h0010, 0, 0, 16'h0011, 0, 0, 0, 0, 0);
      cyc("in_reset", 1, 1, 16'h0010, 0, 0, 16'h0011, 0, 0, 0, 0, 0);
      cyc("post_rst", 0, 1, 16'h0010, 0, 0, 16'h0011, 0, 0, 0, 0, 0);
      cyc("wrap", 0, 1, 16'hFFFF, 0, 0, 16'h0000, 0, 0, 0, 0, 0);

      // train taken branch 0023; same-cycle lookup sees old contents
      cyc("br_same", 0, 1, 16'h0023, 0, 0, 16'h0024,
          1, 16'h0023, 16'h0040, 1, 0);
      cyc("br_hit", 0, 1, 16'h0023, 1, 1, 16'h0040,
          1, 16'h0023, 16'h0000, 0, 0);
      cyc("br_nt1", 0, 1, 16'h0023, CTR, 0, 16'h0024,
          1, 16'h0023, 16'h0000, 0, 0);
      cyc("br_nt2", 0, 1, 16'h0023, CTR, 0, 16'h0024,
          0, 0, 0, 0, 0);

      // jump with upd_taken low still counts as taken
      cyc("jmp_same", 0, 1, 16'h0050, 0, 0, 16'h0051,
          1, 16'h0050, 16'hF012, 0, 1);
      cyc("jmp_hit", 0, 1, 16'h0050, 1, 1, 16'hF012,
          1, 16'h0050, 16'h0000, 0, 0);
      cyc("jmp_nt", 0, 1, 16'h0050, CTR, CTR,
          CTR ? 16'hF012 : 16'h0051, 0, 0, 0, 0, 0);

      // retrain 0023 then alias it with 0133
      cyc("re_same", 0, 1, 16'h0023, CTR, 0, 16'h0024,
          1, 16'h0023, 16'h0040, 1, 0);
      cyc("re_hit", 0, 1, 16'h0023, 1, !CTR,
          CTR ? 16'h0024 : 16'h0040, 0, 0, 0, 0, 0);
      cyc("alias_sm", 0, 1, 16'h0133, 0, 0, 16'h0134,
          1, 16'h0133, 16'h0200, 1, 0);
      cyc("alias_old", 0, 1, 16'h0023, 0, 0, 16'h0024, 0, 0, 0, 0, 0);
      cyc("alias_new", 0, 1, 16'h0133, 1, 1, 16'h0200, 0, 0, 0, 0, 0);

      // not-taken miss leaves table alone
      cyc("nt_miss", 0, 0, 16'h0000, 0, 0, 16'h0001,
          1, 16'h0099, 16'h0300, 0, 0);
      cyc("nt_look", 0, 1, 16'h0099, 0, 0, 16'h009A, 0, 0, 0, 0, 0);

      // taken update refreshes the target of 0050
      cyc("refr_upd", 0, 0, 16'h0000, 0, 0, 16'h0001,
          1, 16'h0050, 16'h0060, 1, 0);
      cyc("refr_look", 0, 1, 16'h0050, 1, 1, 16'h0060, 0, 0, 0, 0, 0);

      // update coincident with reset is discarded
      cyc("rst_upd", 1, 0, 16'h0077, 0, 0, 16'h0078,
          1, 16'h0077, 16'h0100, 1, 1);
      cyc("rst_77", 0, 1, 16'h0077, 0, 0, 16'h0078, 0, 0, 0, 0, 0);
      cyc("rst_133", 0, 1, 16'h0133, 0, 0, 16'h0134, 0, 0, 0, 0, 0);
      cyc("rst_50", 0, 1, 16'h0050, 0, 0, 16'h0051, 0, 0, 0, 0, 0);
      cyc("idle", 0, 0, 16'h0000, 0, 0, 16'h0001, 0, 0, 0, 0, 0);

      @(posedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
